// File: rtl/prog_load_ctrl.sv
// Program loader / run supervisor: streams a base address plus program bytes into
// memory, launches the core on a start edge and watches for halt or timeout.
module prog_load_ctrl #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 256,
  parameter int MAX_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              start,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              core_init,
  output logic [ADDR_W-1:0] core_pc,
  output logic              core_run,
  input  logic              core_halt,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   byte_count
);

  localparam int BCW   = ADDR_W + 1;
  localparam int CNT_W = $clog2(MAX_CYCLES) + 1;
  localparam logic [BCW-1:0]   DEPTH_C   = BCW'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(MAX_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_LOADED = 3'd2,
    S_RUN    = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   base_q, wr_ptr_q, mem_addr_q, core_pc_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [BCW-1:0]      byte_count_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                mem_we_q, core_init_q, core_run_q, done_q, err_q, start_q;
  logic                accept, start_edge;

  assign load_ready = ((state_q == S_IDLE) || (state_q == S_LOAD)) && !clear;
  assign accept     = load_valid && load_ready;
  assign start_edge = start && !start_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      wr_ptr_q     <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      core_init_q  <= 1'b0;
      core_pc_q    <= '0;
      core_run_q   <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      byte_count_q <= '0;
      cnt_q        <= '0;
      start_q      <= 1'b0;
    end else begin
      start_q     <= start;
      mem_we_q    <= 1'b0;
      core_init_q <= 1'b0;
      if (clear) begin
        state_q      <= S_IDLE;
        core_run_q   <= 1'b0;
        done_q       <= 1'b0;
        err_q        <= 1'b0;
        byte_count_q <= '0;
      end else begin
        case (state_q)
          S_IDLE: if (accept) begin
            base_q       <= ADDR_W'(load_data);
            wr_ptr_q     <= ADDR_W'(load_data);
            byte_count_q <= '0;
            state_q      <= S_LOAD;
          end
          S_LOAD: if (accept) begin
            // A full buffer rejects the byte outright rather than overwriting.
            if (byte_count_q == DEPTH_C) begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
            end else begin
              mem_we_q     <= 1'b1;
              mem_addr_q   <= wr_ptr_q;
              mem_wdata_q  <= load_data;
              wr_ptr_q     <= wr_ptr_q + ADDR_W'(1);
              byte_count_q <= byte_count_q + BCW'(1);
              if (load_last) state_q <= S_LOADED;
            end
          end
          S_LOADED, S_DONE: if (start_edge) begin
            state_q     <= S_RUN;
            core_init_q <= 1'b1;
            core_pc_q   <= base_q;
            core_run_q  <= 1'b1;
            done_q      <= 1'b0;
            cnt_q       <= '0;
          end
          S_RUN: begin
            // Halt is tested first so it wins over a coincident timeout.
            if (core_halt) begin
              state_q    <= S_DONE;
              core_run_q <= 1'b0;
              done_q     <= 1'b1;
            end else if (cnt_q == CNT_LAST) begin
              state_q    <= S_ERR;
              core_run_q <= 1'b0;
              err_q      <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          S_ERR: ;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign busy       = (state_q == S_LOAD) || (state_q == S_RUN);
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign core_init  = core_init_q;
  assign core_pc    = core_pc_q;
  assign core_run   = core_run_q;
  assign done       = done_q;
  assign err        = err_q;
  assign byte_count = byte_count_q;

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Bench for prog_load_ctrl: two instances (default sizing and DEPTH=4/MAX_CYCLES=16)
// share one stimulus stream and are each checked every cycle against a phase model.
module tb_prog_load_ctrl;

  logic clk = 1'b0;
  logic rst, clear, load_valid, load_last, start, core_halt;
  logic [7:0] load_data;

  logic [1:0]      load_ready_w, mem_we_w, core_init_w, core_run_w, busy_w, done_w, err_w;
  logic [1:0][7:0] mem_addr_w, mem_wdata_w, core_pc_w;
  logic [1:0][8:0] byte_count_w;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  prog_load_ctrl u_a (
    .clk(clk), .rst(rst), .clear(clear), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready_w[0]), .start(start), .mem_we(mem_we_w[0]),
    .mem_addr(mem_addr_w[0]), .mem_wdata(mem_wdata_w[0]), .core_init(core_init_w[0]),
    .core_pc(core_pc_w[0]), .core_run(core_run_w[0]), .core_halt(core_halt), .busy(busy_w[0]),
    .done(done_w[0]), .err(err_w[0]), .byte_count(byte_count_w[0]));

  prog_load_ctrl #(.DEPTH(4), .MAX_CYCLES(16)) u_b (
    .clk(clk), .rst(rst), .clear(clear), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready_w[1]), .start(start), .mem_we(mem_we_w[1]),
    .mem_addr(mem_addr_w[1]), .mem_wdata(mem_wdata_w[1]), .core_init(core_init_w[1]),
    .core_pc(core_pc_w[1]), .core_run(core_run_w[1]), .core_halt(core_halt), .busy(busy_w[1]),
    .done(done_w[1]), .err(err_w[1]), .byte_count(byte_count_w[1]));

  // Model phases: 0 idle, 1 loading, 2 loaded, 3 running, 4 done, 5 error.
  int dep[2]  = '{256, 4};
  int maxc[2] = '{1024, 16};
  int ph[2], base[2], ptr[2], bc[2], rc[2], we[2], addr[2], wd[2], init[2], pc[2], sp[2];
  int qa[$], qb[$], eq[$];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      ph[i] = 0; base[i] = 0; ptr[i] = 0; bc[i] = 0; rc[i] = 0;
      we[i] = 0; addr[i] = 0; wd[i] = 0; init[i] = 0; pc[i] = 0; sp[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      bit edge_s;
      edge_s = start && (sp[i] == 0);
      sp[i] = start;
      we[i] = 0; init[i] = 0;
      if (clear) begin
        ph[i] = 0; bc[i] = 0;
      end else begin
        case (ph[i])
          0: if (load_valid) begin base[i] = load_data; ptr[i] = load_data; bc[i] = 0; ph[i] = 1; end
          1: if (load_valid) begin
            if (bc[i] == dep[i]) ph[i] = 5;
            else begin
              we[i] = 1; addr[i] = ptr[i]; wd[i] = load_data;
              ptr[i] = (ptr[i] + 1) % 256; bc[i]++;
              if (load_last) ph[i] = 2;
            end
          end
          2, 4: if (edge_s) begin ph[i] = 3; init[i] = 1; pc[i] = base[i]; rc[i] = 0; end
          3: begin
            rc[i]++;
            if (core_halt) ph[i] = 4;
            else if (rc[i] == maxc[i]) ph[i] = 5;
          end
          default: ;
        endcase
      end
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      string s;
      s = $sformatf("[%0d]", i);
      chk({"load_ready", s}, int'(load_ready_w[i]), int'((ph[i] <= 1) && !clear));
      chk({"mem_we", s},     int'(mem_we_w[i]),     we[i]);
      chk({"mem_addr", s},   int'(mem_addr_w[i]),   addr[i]);
      chk({"mem_wdata", s},  int'(mem_wdata_w[i]),  wd[i]);
      chk({"core_init", s},  int'(core_init_w[i]),  init[i]);
      chk({"core_pc", s},    int'(core_pc_w[i]),    pc[i]);
      chk({"core_run", s},   int'(core_run_w[i]),   int'(ph[i] == 3));
      chk({"busy", s},       int'(busy_w[i]),       int'(ph[i] == 1 || ph[i] == 3));
      chk({"done", s},       int'(done_w[i]),       int'(ph[i] == 4));
      chk({"err", s},        int'(err_w[i]),        int'(ph[i] == 5));
      chk({"byte_count", s}, int'(byte_count_w[i]), bc[i]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
    if (mem_we_w[0]) qa.push_back({mem_addr_w[0], mem_wdata_w[0]});
    if (mem_we_w[1]) qb.push_back({mem_addr_w[1], mem_wdata_w[1]});
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    load_valid = 1'b1; load_data = d; load_last = last;
    tick();
    load_valid = 1'b0; load_last = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic chk_writes(input string nm, input int which);
    int n;
    n = (which == 0) ? qa.size() : qb.size();
    chk({nm, "_count"}, n, eq.size());
    for (int k = 0; k < eq.size() && k < n; k++)
      chk($sformatf("%s_w%0d", nm, k), (which == 0) ? qa[k] : qb[k], eq[k]);
  endtask

  initial begin
    rst = 1'b0; clear = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
    start = 1'b0; core_halt = 1'b0;
    model_reset();
    @(negedge clk);
    check_all();
    rst = 1'b1;

    // Normal load and run
    qa.delete(); qb.delete();
    send(8'h55, 1'b0); send(8'h01, 1'b0); send(8'h0A, 1'b0);
    send(8'h02, 1'b0); send(8'hA0, 1'b0); send(8'h03, 1'b1);
    eq = '{16'h5501, 16'h560A, 16'h5702, 16'h58A0, 16'h5903};
    chk_writes("normal_A", 0);
    chk("normal_bc_A", int'(byte_count_w[0]), 5);
    chk("normal_ready_loaded_A", int'(load_ready_w[0]), 0);
    chk("normal_overflow_B", int'(err_w[1]), 1);
    start = 1'b1; tick();
    chk("launch_init_A", int'(core_init_w[0]), 1);
    chk("launch_pc_A", int'(core_pc_w[0]), 8'h55);
    chk("launch_run_A", int'(core_run_w[0]), 1);
    tick();
    chk("init_one_cycle_A", int'(core_init_w[0]), 0);
    ticks(9);
    core_halt = 1'b1; tick(); core_halt = 1'b0;
    chk("halt_done_A", int'(done_w[0]), 1);
    chk("halt_run_A", int'(core_run_w[0]), 0);

    // Relaunch from DONE
    start = 1'b0; tick(); start = 1'b1; tick();
    chk("relaunch_init_A", int'(core_init_w[0]), 1);
    chk("relaunch_pc_A", int'(core_pc_w[0]), 8'h55);
    chk("relaunch_done_A", int'(done_w[0]), 0);
    core_halt = 1'b1; tick(); core_halt = 1'b0;
    do_clear();

    // Wrap-around, then timeout on the small instance
    qa.delete(); qb.delete();
    send(8'hFE, 1'b0); send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b1);
    eq = '{16'hFE11, 16'hFF22, 16'h0033};
    chk_writes("wrap_A", 0);
    chk("wrap_bc_A", int'(byte_count_w[0]), 3);
    start = 1'b0; tick(); start = 1'b1; tick();
    ticks(15);
    chk("pre_timeout_err_B", int'(err_w[1]), 0);
    chk("pre_timeout_run_B", int'(core_run_w[1]), 1);
    tick();
    chk("timeout_err_B", int'(err_w[1]), 1);
    chk("timeout_run_B", int'(core_run_w[1]), 0);
    chk("no_timeout_A", int'(core_run_w[0]), 1);
    do_clear();

    // Halt coincident with timeout
    send(8'h20, 1'b0); send(8'h01, 1'b1);
    start = 1'b0; tick(); start = 1'b1; tick();
    ticks(15);
    core_halt = 1'b1; tick(); core_halt = 1'b0;
    chk("halt_vs_timeout_done_B", int'(done_w[1]), 1);
    chk("halt_vs_timeout_err_B", int'(err_w[1]), 0);
    do_clear();

    // Start qualification
    start = 1'b0; tick(); start = 1'b1; tick();
    chk("idle_start_init_A", int'(core_init_w[0]), 0);
    chk("idle_start_busy_A", int'(busy_w[0]), 0);
    send(8'h30, 1'b0); send(8'hAA, 1'b1); ticks(2);
    chk("held_start_run_A", int'(core_run_w[0]), 0);
    start = 1'b0; tick(); start = 1'b1; tick();
    chk("qual_init_A", int'(core_init_w[0]), 1);
    chk("qual_pc_A", int'(core_pc_w[0]), 8'h30);
    core_halt = 1'b1; tick(); core_halt = 1'b0;
    do_clear();

    // Byte offered during clear is dropped; then overflow on the small instance
    clear = 1'b1; load_valid = 1'b1; load_data = 8'h99; tick();
    clear = 1'b0; load_valid = 1'b0;
    chk("clear_drop_busy_A", int'(busy_w[0]), 0);
    qa.delete(); qb.delete();
    send(8'h10, 1'b0);
    for (int k = 0; k < 5; k++) send(8'hB1 + 8'(k), 1'b0);
    eq = '{16'h10B1, 16'h11B2, 16'h12B3, 16'h13B4};
    chk_writes("overflow_B", 1);
    chk("overflow_err_B", int'(err_w[1]), 1);
    chk("overflow_bc_B", int'(byte_count_w[1]), 4);
    do_clear();
    chk("clear_err_B", int'(err_w[1]), 0);
    chk("clear_bc_B", int'(byte_count_w[1]), 0);

    // Async reset mid-load
    send(8'h40, 1'b0); send(8'h01, 1'b0); send(8'h02, 1'b0);
    chk("preres_we_A", int'(mem_we_w[0]), 1);
    #2 rst = 1'b0;
    #1 model_reset();
    check_all();
    chk("res_we_A", int'(mem_we_w[0]), 0);
    chk("res_busy_A", int'(busy_w[0]), 0);
    @(negedge clk);
    check_all();
    rst = 1'b1;
    qa.delete();
    send(8'h70, 1'b0); send(8'h05, 1'b1);
    eq = '{16'h7005};
    chk_writes("post_reset_A", 0);
    ticks(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/prog_load_ctrl.md
Name: prog_load_ctrl

Overview:
Sequencing controller in front of the 8-bit processor-with-memory. Accepts a byte stream whose first byte is the program start address and whose remaining bytes are program contents. Writes the program bytes into program memory at consecutive addresses, launches the core on a start edge, and supervises the run until halt or timeout. Sits between the host/testbench byte interface and the processor core/memory.

Parameters:
ADDR_W, 8, memory address width; addresses wrap modulo 2^ADDR_W.
DATA_W, 8, byte width.
DEPTH, 256, maximum number of program bytes per load.
MAX_CYCLES, 1024, run-timeout limit in clock cycles; width of the internal counter is clog2(MAX_CYCLES)+1.

Ports:
clk  in  1  clock; all state changes on rising edge.
rst  in  1  asynchronous, active-low reset.
clear  in  1  synchronous abort; returns the block to IDLE.
load_valid  in  1  byte-stream valid.
load_data  in  DATA_W  stream byte.
load_last  in  1  marks the final program byte.
load_ready  out  1  block can accept a byte this cycle.
start  in  1  level input; only its rising edge is used.
mem_we  out  1  memory write strobe.
mem_addr  out  ADDR_W  memory write address.
mem_wdata  out  DATA_W  memory write data.
core_init  out  1  one-cycle pulse that loads core PC.
core_pc  out  ADDR_W  PC value presented with core_init; equals latched base address.
core_run  out  1  core enable.
core_halt  in  1  core reports halt.
busy  out  1  high in LOAD and RUN.
done  out  1  high in DONE.
err  out  1  high in ERR.
byte_count  out  ADDR_W+1  program bytes written in the current load.

Behaviour:
- Reset (rst=0, async): state=IDLE. All registered outputs=0: mem_we, mem_addr, mem_wdata, core_init, core_pc, core_run, done, err, byte_count. Base address=0. Start-edge register=0.
- Handshake: a byte is accepted when load_valid & load_ready. load_ready = (state==IDLE || state==LOAD) & ~clear, combinational.
- start_edge = start & ~start_q, where start_q is registered start.
- IDLE: an accepted byte is the base address. Latch it into base and wr_ptr, set byte_count=0, go to LOAD. load_last on the address byte is ignored. start is ignored.
- LOAD: each accepted byte produces, on the next cycle, mem_we=1, mem_addr=wr_ptr, mem_wdata=byte. Then wr_ptr increments (wraps 0xFF->0x00) and byte_count increments. mem_we is low on any cycle without a write. An accepted byte with load_last=1 is written, then the state goes to LOADED. If a byte is accepted while byte_count==DEPTH, that byte is not written and the state goes to ERR. start is ignored in LOAD.
- LOADED: load_ready=0. start_edge moves the state to RUN. On the same edge, core_init=1 for exactly one cycle, core_pc=base, and core_run=1.
- RUN: core_run=1 and the cycle counter increments each cycle. core_halt=1 moves the state to DONE with core_run=0 on the next cycle. If the counter reaches MAX_CYCLES first, the state goes to ERR with core_run=0. If core_halt and timeout occur in the same cycle, halt wins.
- DONE: done=1. start_edge re-launches: state=RUN, core_init pulse, counter cleared, program unchanged.
- ERR: err=1 and core_run=0. The block stays in ERR until clear or reset.
- clear: highest priority after reset, in any state. Next state=IDLE. Cleared: core_run, done, err, mem_we, byte_count. A byte presented in the same cycle is not accepted. Memory contents are untouched.
- Reset asserted mid-load or mid-run: outputs drop immediately to their reset values; no partial write is completed after reset.
- State encoding: IDLE=0, LOAD=1, LOADED=2, RUN=3, DONE=4, ERR=5.

Test Plan:
- Normal load and run. After reset release, stream 0x55, 0x01, 0x0A, 0x02, 0xA0, 0x03 (last) -> writes (0x55,0x01), (0x56,0x0A), (0x57,0x02), (0x58,0xA0), (0x59,0x03); byte_count=5; state LOADED. Then start 0->1 -> one-cycle core_init with core_pc=0x55, core_run=1. Then core_halt after 10 cycles -> done=1, core_run=0.
- Wrap-around. Base 0xFE, bytes 0x11, 0x22, 0x33 (last) -> writes at 0xFE, 0xFF, 0x00; byte_count=3.
- Overflow. DEPTH=4, base 0x10, five bytes with no last -> four writes at 0x10..0x13; fifth byte not written; err=1. Then clear -> IDLE, err=0.
- Timeout. MAX_CYCLES=16, run with core_halt held low -> err=1 and core_run=0 after 16 run cycles. Halt and timeout in the same cycle -> done=1, err=0.
- Start qualification. start held high through the load -> no launch until start falls and rises again in LOADED. start in IDLE -> no core_init. start in DONE -> second run with core_pc=base.
- Async reset mid-load. rst=0 between bytes 2 and 3 -> mem_we=0 immediately, state IDLE. After release, next byte is treated as the base address.
